// File: rtl/cpu_pc_seq_if.sv
// Decoder/counter-side bundle for the program-counter sequencer.
// The master drives strobes and the current PC; the slave (sequencer) drives the counter controls.
interface cpu_pc_seq_if #(
  parameter int WIDTH = 8,
  parameter int SP_W  = 4
);
  logic [WIDTH-1:0] pc_in;
  logic [WIDTH-1:0] target;
  logic             jmp;
  logic             jz;
  logic             zero;
  logic             call;
  logic             ret;
  logic             halt;
  logic             wake;
  logic             fault_clr;

  logic             pc_rst;
  logic             pc_ld;
  logic [WIDTH-1:0] pc_addr;
  logic [SP_W-1:0]  sp;
  logic             stk_full;
  logic             stk_empty;
  logic             halted;
  logic             fault;

  modport master (
    output pc_in, target, jmp, jz, zero, call, ret, halt, wake, fault_clr,
    input  pc_rst, pc_ld, pc_addr, sp, stk_full, stk_empty, halted, fault
  );

  modport slave (
    input  pc_in, target, jmp, jz, zero, call, ret, halt, wake, fault_clr,
    output pc_rst, pc_ld, pc_addr, sp, stk_full, stk_empty, halted, fault
  );
endinterface

// File: rtl/cpu_pc_seq.sv
// Next-address sequencer: turns control-flow strobes into counter load/reset controls,
// with a return-address stack, halt/wake FSM and a sticky fault on stack misuse.
module cpu_pc_seq #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 8,
  parameter int               SP_W      = 4,
  parameter logic [WIDTH-1:0] FAULT_VEC = 8'hF0
) (
  input  logic         clk,
  input  logic         rst_n,
  cpu_pc_seq_if.slave  bus
);

  localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SP_W-1:0] DEPTH_SP = SP_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_RST_HOLD = 2'd0,
    ST_RUN      = 2'd1,
    ST_HALTED   = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [SP_W-1:0]  sp_reg, sp_next;
  logic             fault_reg, fault_next;
  logic             fault_set;

  logic [WIDTH-1:0] stack_mem [DEPTH];
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] top_data;

  logic             pc_rst;
  logic             pc_ld;
  logic [WIDTH-1:0] pc_addr;

  // The return address is the instruction after the call, wrapping at the top of memory.
  assign push_data = bus.pc_in + WIDTH'(1);
  assign push_idx  = AW'(sp_reg);
  assign top_idx   = AW'(sp_reg - SP_W'(1));
  assign top_data  = stack_mem[top_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_RST_HOLD;
      sp_reg    <= '0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      sp_reg    <= sp_next;
      fault_reg <= fault_next;
    end
  end

  // Stack contents need no reset; only the pointer defines what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_mem[push_idx] <= push_data;
    end
  end

  always_comb begin
    state_next = state_reg;
    sp_next    = sp_reg;
    fault_set  = 1'b0;
    push       = 1'b0;
    pc_rst     = 1'b0;
    pc_ld      = 1'b0;
    pc_addr    = '0;

    case (state_reg)
      ST_RST_HOLD: begin
        pc_rst     = 1'b1;
        state_next = ST_RUN;
      end

      ST_RUN: begin
        if (bus.halt) begin
          pc_ld      = 1'b1;
          pc_addr    = bus.pc_in;
          state_next = ST_HALTED;
        end else if (bus.ret) begin
          pc_ld = 1'b1;
          if (sp_reg != '0) begin
            pc_addr = top_data;
            sp_next = sp_reg - SP_W'(1);
          end else begin
            pc_addr   = FAULT_VEC;
            fault_set = 1'b1;
          end
        end else if (bus.call) begin
          pc_ld = 1'b1;
          if (sp_reg != DEPTH_SP) begin
            push    = 1'b1;
            pc_addr = bus.target;
            sp_next = sp_reg + SP_W'(1);
          end else begin
            pc_addr   = FAULT_VEC;
            fault_set = 1'b1;
          end
        end else if (bus.jmp || (bus.jz && bus.zero)) begin
          pc_ld   = 1'b1;
          pc_addr = bus.target;
        end
      end

      ST_HALTED: begin
        // Releasing the load lets the counter step past the HALT instruction.
        if (bus.wake) begin
          state_next = ST_RUN;
        end else begin
          pc_ld   = 1'b1;
          pc_addr = bus.pc_in;
        end
      end

      default: begin
        pc_rst     = 1'b1;
        state_next = ST_RST_HOLD;
      end
    endcase

    fault_next = fault_set | (fault_reg & ~bus.fault_clr);
  end

  assign bus.pc_rst    = pc_rst;
  assign bus.pc_ld     = pc_ld;
  assign bus.pc_addr   = pc_addr;
  assign bus.sp        = sp_reg;
  assign bus.stk_full  = (sp_reg == DEPTH_SP);
  assign bus.stk_empty = (sp_reg == '0);
  assign bus.halted    = (state_reg == ST_HALTED);
  assign bus.fault     = fault_reg;

endmodule

// File: tb/tb_cpu_pc_seq.sv
// Self-checking bench for cpu_pc_seq: directed scenarios plus randomized strobes
// checked against a queue-based model of the sequencer, driving a behavioural counter.
module tb_cpu_pc_seq;

  localparam int         WIDTH = 8;
  localparam int         DEPTH = 8;
  localparam int         SP_W  = 4;
  localparam logic [7:0] FV    = 8'hF0;

  logic       clk;
  logic       rst_n;
  logic [7:0] pc_q;

  int n_cmp = 0;
  int n_err = 0;

  cpu_pc_seq_if #(.WIDTH(WIDTH), .SP_W(SP_W)) bus ();

  cpu_pc_seq #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .SP_W(SP_W), .FAULT_VEC(FV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter being sequenced: sync reset, load, otherwise increment.
  assign bus.pc_in = pc_q;
  always @(posedge clk) begin
    if (bus.pc_rst)     pc_q <= 8'h00;
    else if (bus.pc_ld) pc_q <= bus.pc_addr;
    else                pc_q <= pc_q + 8'h01;
  end

  // Reference model: return stack as a queue, plus halted / fault / reset-hold flags.
  logic [7:0] m_stack[$];
  logic [7:0] n_stack[$];
  bit         m_hold, m_halted, m_fault;
  bit         n_hold, n_halted, n_fault;
  logic       exp_rst, exp_ld;
  logic [7:0] exp_addr;

  task automatic model_reset();
    m_stack.delete();
    m_hold   = 1'b1;
    m_halted = 1'b0;
    m_fault  = 1'b0;
  endtask

  task automatic predict();
    n_stack  = m_stack;
    n_hold   = m_hold;
    n_halted = m_halted;
    n_fault  = m_fault && !bus.fault_clr;
    exp_rst  = 1'b0;
    exp_ld   = 1'b0;
    exp_addr = 8'h00;
    if (!rst_n) begin
      n_stack.delete();
      n_hold   = 1'b1;
      n_halted = 1'b0;
      n_fault  = 1'b0;
      exp_rst  = 1'b1;
    end else if (m_hold) begin
      exp_rst = 1'b1;
      n_hold  = 1'b0;
    end else if (m_halted) begin
      if (bus.wake) n_halted = 1'b0;
      else begin exp_ld = 1'b1; exp_addr = pc_q; end
    end else if (bus.halt) begin
      exp_ld = 1'b1; exp_addr = pc_q; n_halted = 1'b1;
    end else if (bus.ret) begin
      exp_ld = 1'b1;
      if (m_stack.size() > 0) begin
        exp_addr = m_stack[$];
        void'(n_stack.pop_back());
      end else begin
        exp_addr = FV; n_fault = 1'b1;
      end
    end else if (bus.call) begin
      exp_ld = 1'b1;
      if (m_stack.size() < DEPTH) begin
        n_stack.push_back(8'(pc_q + 8'd1));
        exp_addr = bus.target;
      end else begin
        exp_addr = FV; n_fault = 1'b1;
      end
    end else if (bus.jmp || (bus.jz && bus.zero)) begin
      exp_ld = 1'b1; exp_addr = bus.target;
    end
  endtask

  task automatic clear_strobes();
    bus.target = 8'h00; bus.jmp = 0; bus.jz = 0; bus.zero = 0; bus.call = 0;
    bus.ret = 0; bus.halt = 0; bus.wake = 0; bus.fault_clr = 0;
  endtask

  task automatic settle();
    #1;
    predict();
  endtask

  // One clock: the model advances on the same edge as the DUT, then return to the falling edge.
  task automatic tick();
    predict();
    @(posedge clk);
    m_stack  = n_stack;
    m_hold   = n_hold;
    m_halted = n_halted;
    m_fault  = n_fault;
    @(negedge clk);
  endtask

  task automatic jump_to(input logic [7:0] a);
    bus.jmp = 1; bus.target = a;
    tick();
    clear_strobes();
  endtask

  task automatic test_reset();
    clear_strobes();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (bus.pc_rst !== 1'b1) begin n_err++; $display("FAIL rst_pc_rst: got %0b want 1", bus.pc_rst); end
    n_cmp++; if (bus.pc_ld !== 1'b0) begin n_err++; $display("FAIL rst_pc_ld: got %0b want 0", bus.pc_ld); end
    n_cmp++; if (bus.pc_addr !== 8'h00) begin n_err++; $display("FAIL rst_pc_addr: got %h want 00", bus.pc_addr); end
    n_cmp++; if (bus.sp !== 4'd0 || bus.stk_empty !== 1'b1) begin n_err++; $display("FAIL rst_sp: got sp=%0d empty=%0b want 0/1", bus.sp, bus.stk_empty); end
    n_cmp++; if (bus.fault !== 1'b0 || bus.halted !== 1'b0) begin n_err++; $display("FAIL rst_flags: got fault=%0b halted=%0b want 0/0", bus.fault, bus.halted); end
    @(negedge clk);
    rst_n = 1'b1;
    settle();
    n_cmp++; if (bus.pc_rst !== 1'b1) begin n_err++; $display("FAIL hold_pc_rst: got %0b want 1", bus.pc_rst); end
    tick();
    settle();
    n_cmp++; if (bus.pc_rst !== 1'b0) begin n_err++; $display("FAIL run_pc_rst: got %0b want 0", bus.pc_rst); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (pc_q !== 8'(i)) begin n_err++; $display("FAIL run_count%0d: got %h want %h", i, pc_q, 8'(i)); end
      $display("reset: cycle %0d pc=%h sp=%0d", i, pc_q, bus.sp);
      tick();
    end
  endtask

  task automatic test_call_ret();
    jump_to(8'h05);
    bus.call = 1; bus.target = 8'h40;
    settle();
    n_cmp++; if (bus.pc_ld !== 1'b1 || bus.pc_addr !== 8'h40) begin n_err++; $display("FAIL call_addr: got ld=%0b addr=%h want 1/40", bus.pc_ld, bus.pc_addr); end
    tick(); clear_strobes(); settle();
    n_cmp++; if (bus.sp !== 4'd1 || pc_q !== 8'h40) begin n_err++; $display("FAIL call_sp: got sp=%0d pc=%h want 1/40", bus.sp, pc_q); end
    $display("call: pc=05 target=40 sp=%0d", bus.sp);
    tick(); tick();
    bus.ret = 1;
    settle();
    n_cmp++; if (pc_q !== 8'h42 || bus.pc_addr !== 8'h06) begin n_err++; $display("FAIL ret_addr: got pc=%h addr=%h want 42/06", pc_q, bus.pc_addr); end
    tick(); clear_strobes(); settle();
    n_cmp++; if (bus.sp !== 4'd0 || pc_q !== 8'h06) begin n_err++; $display("FAIL ret_sp: got sp=%0d pc=%h want 0/06", bus.sp, pc_q); end
    $display("ret: pc=42 return=06 sp=%0d", bus.sp);
    // Return address wraps when the call sits at the last address.
    jump_to(8'hFF);
    bus.call = 1; bus.target = 8'h40;
    tick(); clear_strobes();
    bus.ret = 1;
    settle();
    n_cmp++; if (bus.pc_addr !== 8'h00) begin n_err++; $display("FAIL wrap_ret: got %h want 00", bus.pc_addr); end
    $display("wrap: call at ff returns to %h", bus.pc_addr);
    tick(); clear_strobes();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      bus.call = 1; bus.target = 8'(8'h80 + 4 * i);
      settle();
      n_cmp++; if (bus.pc_addr !== bus.target) begin n_err++; $display("FAIL nest_call%0d: got %h want %h", i, bus.pc_addr, bus.target); end
      tick();
    end
    settle();
    n_cmp++; if (bus.sp !== 4'd8 || bus.stk_full !== 1'b1) begin n_err++; $display("FAIL nest_full: got sp=%0d full=%0b want 8/1", bus.sp, bus.stk_full); end
    settle();
    n_cmp++; if (bus.pc_addr !== FV) begin n_err++; $display("FAIL ovf_addr: got %h want f0", bus.pc_addr); end
    tick(); clear_strobes(); settle();
    n_cmp++; if (bus.fault !== 1'b1 || bus.sp !== 4'd8 || pc_q !== FV) begin n_err++; $display("FAIL ovf_state: got fault=%0b sp=%0d pc=%h want 1/8/f0", bus.fault, bus.sp, pc_q); end
    $display("overflow: fault=%0b sp=%0d full=%0b", bus.fault, bus.sp, bus.stk_full);
    bus.fault_clr = 1;
    tick(); clear_strobes(); settle();
    n_cmp++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %0b want 0", bus.fault); end
    for (int i = 0; i < DEPTH; i++) begin
      bus.ret = 1;
      settle();
      n_cmp++; if (bus.pc_addr !== exp_addr) begin n_err++; $display("FAIL unwind%0d: got %h want %h", i, bus.pc_addr, exp_addr); end
      $display("unwind: level %0d return=%h", i, bus.pc_addr);
      tick();
    end
    clear_strobes();
  endtask

  task automatic test_underflow_priority();
    bus.ret = 1;
    settle();
    n_cmp++; if (bus.pc_addr !== FV || bus.pc_ld !== 1'b1) begin n_err++; $display("FAIL udf_addr: got ld=%0b addr=%h want 1/f0", bus.pc_ld, bus.pc_addr); end
    tick(); clear_strobes(); settle();
    n_cmp++; if (bus.fault !== 1'b1 || bus.sp !== 4'd0) begin n_err++; $display("FAIL udf_state: got fault=%0b sp=%0d want 1/0", bus.fault, bus.sp); end
    // A new fault on the same edge as a clear keeps the flag set.
    bus.ret = 1; bus.fault_clr = 1;
    tick(); clear_strobes(); settle();
    n_cmp++; if (bus.fault !== 1'b1) begin n_err++; $display("FAIL set_wins: got %0b want 1", bus.fault); end
    jump_to(8'h33);
    bus.call = 1; bus.jmp = 1; bus.jz = 1; bus.zero = 1; bus.target = 8'h20;
    tick(); clear_strobes(); settle();
    n_cmp++; if (bus.sp !== 4'd1 || pc_q !== 8'h20) begin n_err++; $display("FAIL prio_call: got sp=%0d pc=%h want 1/20", bus.sp, pc_q); end
    $display("priority: call+jmp+jz -> pc=%h sp=%0d", pc_q, bus.sp);
    bus.ret = 1; bus.call = 1; bus.target = 8'h77;
    settle();
    n_cmp++; if (bus.pc_addr !== 8'h34) begin n_err++; $display("FAIL prio_ret: got %h want 34", bus.pc_addr); end
    tick(); clear_strobes();
    bus.fault_clr = 1;
    tick(); clear_strobes();
  endtask

  task automatic test_halt_wake();
    jump_to(8'h10);
    bus.halt = 1;
    tick(); clear_strobes(); settle();
    n_cmp++; if (bus.halted !== 1'b1 || pc_q !== 8'h10) begin n_err++; $display("FAIL halt_enter: got halted=%0b pc=%h want 1/10", bus.halted, pc_q); end
    for (int i = 0; i < 5; i++) begin
      bus.jmp = 1; bus.target = 8'h77;
      tick(); settle();
      n_cmp++; if (pc_q !== 8'h10) begin n_err++; $display("FAIL halt_hold%0d: got %h want 10", i, pc_q); end
      $display("halted: cycle %0d pc=%h", i, pc_q);
    end
    clear_strobes();
    bus.wake = 1;
    settle();
    n_cmp++; if (bus.pc_ld !== 1'b0) begin n_err++; $display("FAIL wake_ld: got %0b want 0", bus.pc_ld); end
    tick(); clear_strobes(); settle();
    n_cmp++; if (pc_q !== 8'h11 || bus.halted !== 1'b0) begin n_err++; $display("FAIL wake_state: got pc=%h halted=%0b want 11/0", pc_q, bus.halted); end
    $display("wake: pc=%h halted=%0b", pc_q, bus.halted);
  endtask

  task automatic test_jz_async_reset();
    jump_to(8'h30);
    bus.jz = 1; bus.zero = 0; bus.target = 8'h50;
    tick(); clear_strobes(); settle();
    n_cmp++; if (pc_q !== 8'h31) begin n_err++; $display("FAIL jz_not_taken: got %h want 31", pc_q); end
    bus.jz = 1; bus.zero = 1; bus.target = 8'h50;
    tick(); clear_strobes(); settle();
    n_cmp++; if (pc_q !== 8'h50) begin n_err++; $display("FAIL jz_taken: got %h want 50", pc_q); end
    $display("jz: not-taken then taken -> pc=%h", pc_q);
    bus.call = 1; bus.target = 8'h60;
    tick(); clear_strobes();
    bus.halt = 1;
    tick(); clear_strobes();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (bus.halted !== 1'b0 || bus.sp !== 4'd0 || bus.pc_rst !== 1'b1) begin n_err++; $display("FAIL async_rst: got halted=%0b sp=%0d pc_rst=%0b want 0/0/1", bus.halted, bus.sp, bus.pc_rst); end
    $display("async reset mid-halt: halted=%0b sp=%0d", bus.halted, bus.sp);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_n         = ($urandom_range(0, 99) != 0);
      if (!rst_n) model_reset();
      bus.target    = 8'($urandom);
      bus.halt      = ($urandom_range(0, 99) < 4);
      bus.ret       = ($urandom_range(0, 99) < 12);
      bus.call      = ($urandom_range(0, 99) < 22);
      bus.jmp       = ($urandom_range(0, 99) < 10);
      bus.jz        = ($urandom_range(0, 99) < 15);
      bus.zero      = ($urandom_range(0, 99) < 50);
      bus.wake      = ($urandom_range(0, 99) < 30);
      bus.fault_clr = ($urandom_range(0, 99) < 6);
      settle();
      n_cmp++; if (bus.pc_rst !== exp_rst || bus.pc_ld !== exp_ld) begin n_err++; $display("FAIL rnd_ctl c%0d: got rst=%0b ld=%0b want %0b/%0b", c, bus.pc_rst, bus.pc_ld, exp_rst, exp_ld); end
      if (exp_ld || exp_rst) begin
        n_cmp++; if (bus.pc_addr !== exp_addr) begin n_err++; $display("FAIL rnd_addr c%0d: got %h want %h", c, bus.pc_addr, exp_addr); end
      end
      n_cmp++; if (bus.sp !== 4'(m_stack.size()) || bus.stk_full !== (m_stack.size() == DEPTH) || bus.stk_empty !== (m_stack.size() == 0)) begin
        n_err++; $display("FAIL rnd_stack c%0d: got sp=%0d full=%0b empty=%0b want sp=%0d", c, bus.sp, bus.stk_full, bus.stk_empty, m_stack.size());
      end
      n_cmp++; if (bus.halted !== m_halted || bus.fault !== m_fault) begin n_err++; $display("FAIL rnd_flags c%0d: got halted=%0b fault=%0b want %0b/%0b", c, bus.halted, bus.fault, m_halted, m_fault); end
      $display("rand %0d: rst_n=%0b pc=%h ld=%0b addr=%h sp=%0d halted=%0b fault=%0b", c, rst_n, pc_q, bus.pc_ld, bus.pc_addr, bus.sp, bus.halted, bus.fault);
      tick();
    end
    rst_n = 1'b1;
    clear_strobes();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_strobes();
    model_reset();
    @(negedge clk);
    test_reset();
    test_call_ret();
    test_overflow();
    test_underflow_priority();
    test_halt_wake();
    test_jz_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
